// File: rtl/raw2rgb_bayer_if.sv
// Video bundle between the raw pixel source and the demosaic: raw stream in,
// RGB stream out. The master side drives the raw stream and receives RGB.
interface raw2rgb_bayer_if #(
  parameter int DATA_W = 8
);
  logic              i_vga_vsync;
  logic              i_vga_hsync;
  logic              i_vga_de;
  logic [DATA_W-1:0] i_raw_data;
  logic              o_vga_vsync;
  logic              o_vga_hsync;
  logic              o_vga_de;
  logic [DATA_W-1:0] o_vga_r;
  logic [DATA_W-1:0] o_vga_g;
  logic [DATA_W-1:0] o_vga_b;

  modport master (
    output i_vga_vsync, i_vga_hsync, i_vga_de, i_raw_data,
    input  o_vga_vsync, o_vga_hsync, o_vga_de, o_vga_r, o_vga_g, o_vga_b
  );

  modport slave (
    input  i_vga_vsync, i_vga_hsync, i_vga_de, i_raw_data,
    output o_vga_vsync, o_vga_hsync, o_vga_de, o_vga_r, o_vga_g, o_vga_b
  );
endinterface

// File: rtl/raw2rgb_bayer.sv
// Bayer RAW to RGB demosaic with a 2x2 window, one inferred line buffer and a
// two-cycle pipeline; the first row and column of each frame are blanked.
module raw2rgb_bayer #(
  parameter int DATA_W   = 8,
  parameter int LINE_MAX = 2048,
  parameter int ADDR_W   = 11
) (
  input  logic            sclk,
  input  logic            s_rst_n,
  input  logic [1:0]      i_pattern,
  raw2rgb_bayer_if.slave  vga,
  output logic            o_line_ovf
);

  localparam int                COL_W   = ADDR_W + 1;
  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(LINE_MAX);

  typedef enum logic [1:0] {
    PH_R  = 2'b00,
    PH_GR = 2'b01,
    PH_GB = 2'b10,
    PH_B  = 2'b11
  } phase_e;

  function automatic logic [DATA_W-1:0] avg2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(1);
    return s[DATA_W:1];
  endfunction

  // Stage 0: position tracking and latched pattern
  logic [COL_W-1:0]  r_col;
  logic [15:0]       r_row;
  logic [1:0]        r_pat;
  logic              r_de_p;
  logic              r_ovf;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_addr;

  assign w_in_range = (r_col < COL_MAX);
  assign w_addr     = r_col[ADDR_W-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_pat  <= '0;
      r_de_p <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_de_p <= vga.i_vga_de;

      if (!vga.i_vga_de)       r_col <= '0;
      else if (r_col != COL_MAX) r_col <= r_col + COL_W'(1);

      if (vga.i_vga_vsync)                r_row <= '0;
      else if (r_de_p && !vga.i_vga_de)   r_row <= r_row + 16'd1;

      if (vga.i_vga_vsync) r_pat <= i_pattern;

      // Frame sync clears the flag even if an overlong pixel arrives with it.
      if (vga.i_vga_vsync)                   r_ovf <= 1'b0;
      else if (vga.i_vga_de && !w_in_range)  r_ovf <= 1'b1;
    end
  end

  assign o_line_ovf = r_ovf;

  // Line buffer: read-before-write returns the pixel one row above.
  logic [DATA_W-1:0] r_mem [LINE_MAX];
  logic [DATA_W-1:0] r_above;

  // NOTE: the line memory and its read register carry no reset so they map
  // onto block RAM; stale contents are harmless because row 0 is blanked.
  always_ff @(posedge sclk) begin
    if (vga.i_vga_de && w_in_range) begin
      r_above        <= r_mem[w_addr];
      r_mem[w_addr]  <= vga.i_raw_data;
    end
  end

  // Stage 1: 2x2 window plus control carried alongside it
  logic [DATA_W-1:0] r_br;
  logic [DATA_W-1:0] r_bl;
  logic [DATA_W-1:0] r_tl;
  phase_e            r_s1_phase;
  logic              r_s1_zero;
  logic              r_s1_de;
  logic              r_s1_vs;
  logic              r_s1_hs;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_br       <= '0;
      r_bl       <= '0;
      r_tl       <= '0;
      r_s1_phase <= PH_R;
      r_s1_zero  <= 1'b0;
      r_s1_de    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_s1_hs    <= 1'b0;
    end else begin
      r_br       <= vga.i_raw_data;
      r_bl       <= r_br;
      r_tl       <= r_above;
      r_s1_phase <= phase_e'({r_row[0] ^ r_pat[1], r_col[0] ^ r_pat[0]});
      r_s1_zero  <= (r_row == 16'd0) || (r_col == '0) || !w_in_range;
      r_s1_de    <= vga.i_vga_de;
      r_s1_vs    <= vga.i_vga_vsync;
      r_s1_hs    <= vga.i_vga_hsync;
    end
  end

  // TR is the registered RAM read itself; the other three taps are flops.
  logic [DATA_W-1:0] w_r;
  logic [DATA_W-1:0] w_g;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_avg_diag;
  logic [DATA_W-1:0] w_avg_anti;

  assign w_avg_diag = avg2(r_br, r_tl);
  assign w_avg_anti = avg2(r_bl, r_above);

  // NOTE: every always_comb output gets a default first so no path can infer
  // a latch.
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    unique case (r_s1_phase)
      PH_R: begin
        w_r = r_br;
        w_g = w_avg_anti;
        w_b = r_tl;
      end
      PH_B: begin
        w_r = r_tl;
        w_g = w_avg_anti;
        w_b = r_br;
      end
      PH_GR: begin
        w_r = r_bl;
        w_g = w_avg_diag;
        w_b = r_above;
      end
      PH_GB: begin
        w_r = r_above;
        w_g = w_avg_diag;
        w_b = r_bl;
      end
      default: ;
    endcase
  end

  // Stage 2: output registers, colour forced to black outside valid pixels
  logic w_show;
  assign w_show = r_s1_de && !r_s1_zero;

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      vga.o_vga_vsync <= 1'b0;
      vga.o_vga_hsync <= 1'b0;
      vga.o_vga_de    <= 1'b0;
      vga.o_vga_r     <= '0;
      vga.o_vga_g     <= '0;
      vga.o_vga_b     <= '0;
    end else begin
      vga.o_vga_vsync <= r_s1_vs;
      vga.o_vga_hsync <= r_s1_hs;
      vga.o_vga_de    <= r_s1_de;
      vga.o_vga_r     <= w_show ? w_r : '0;
      vga.o_vga_g     <= w_show ? w_g : '0;
      vga.o_vga_b     <= w_show ? w_b : '0;
    end
  end

endmodule

// File: tb/tb_raw2rgb_bayer.sv
// Directed bench for raw2rgb_bayer: small frames with hand-computed colours,
// a capture monitor on the output stream, and one check task.
module tb_raw2rgb_bayer;

  localparam int DATA_W   = 8;
  localparam int LINE_MAX = 8;
  localparam int ADDR_W   = 3;
  localparam int MAX_R    = 4;
  localparam int MAX_C    = 10;

  localparam logic [23:0] RGGB_RGB = {8'd200, 8'd100, 8'd50};
  localparam logic [23:0] SWAP_RGB = {8'd50, 8'd100, 8'd200};
  localparam logic [23:0] EMPTY    = 24'hFFFFFF;

  logic       sclk = 1'b0;
  logic       s_rst_n = 1'b0;
  logic [1:0] i_pattern = 2'd0;
  logic       o_line_ovf;

  raw2rgb_bayer_if #(.DATA_W(DATA_W)) vga();

  raw2rgb_bayer #(
    .DATA_W   (DATA_W),
    .LINE_MAX (LINE_MAX),
    .ADDR_W   (ADDR_W)
  ) dut (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .i_pattern  (i_pattern),
    .vga        (vga),
    .o_line_ovf (o_line_ovf)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Output capture, indexed by output row/column, cleared on each output vsync.
  logic [DATA_W-1:0] pix [0:MAX_R-1][0:MAX_C-1];
  logic [23:0]       cap [0:MAX_R-1][0:MAX_C-1];
  int                cap_cnt = 0;
  int                mrow = 0;
  int                mcol = 0;
  logic              prev_de = 1'b0;

  always @(negedge sclk) begin
    if (vga.o_vga_vsync) begin
      mrow = 0;
      mcol = 0;
      cap_cnt = 0;
      for (int r = 0; r < MAX_R; r++)
        for (int c = 0; c < MAX_C; c++)
          cap[r][c] = EMPTY;
    end else if (vga.o_vga_de) begin
      if (mrow < MAX_R && mcol < MAX_C)
        cap[mrow][mcol] = {vga.o_vga_r, vga.o_vga_g, vga.o_vga_b};
      mcol++;
      cap_cnt++;
    end else if (prev_de) begin
      mrow++;
      mcol = 0;
    end
    prev_de = vga.o_vga_de;
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic drive_line(input int r, input int cols);
    vga.i_vga_hsync = 1'b1;
    tick();
    vga.i_vga_hsync = 1'b0;
    tick();
    for (int c = 0; c < cols; c++) begin
      vga.i_vga_de   = 1'b1;
      vga.i_raw_data = pix[r][c];
      tick();
    end
    vga.i_vga_de   = 1'b0;
    vga.i_raw_data = '0;
    repeat (2) tick();
  endtask

  task automatic drive_frame(input logic [1:0] pat_vs, input logic [1:0] pat_mid,
                             input int rows, input int cols);
    vga.i_vga_vsync = 1'b1;
    i_pattern       = pat_vs;
    repeat (2) tick();
    vga.i_vga_vsync = 1'b0;
    i_pattern       = pat_mid;
    tick();
    for (int r = 0; r < rows; r++) drive_line(r, cols);
    repeat (3) tick();
  endtask

  task automatic check_frame(input string tag, input int rows, input int cols,
                             input logic [23:0] interior);
    logic [23:0] exp;
    check($sformatf("%s_count", tag), 32'(cap_cnt), 32'(rows * cols));
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        exp = (r == 0 || c == 0 || c >= LINE_MAX) ? 24'd0 : interior;
        check($sformatf("%s_px%0d_%0d", tag, r, c), 32'(cap[r][c]), 32'(exp));
      end
  endtask

  task automatic fill_flat();
    for (int r = 0; r < MAX_R; r++)
      for (int c = 0; c < MAX_C; c++)
        pix[r][c] = (r % 2 == 0) ? ((c % 2 == 0) ? 8'd200 : 8'd100)
                                 : ((c % 2 == 0) ? 8'd100 : 8'd50);
  endtask

  initial begin
    vga.i_vga_vsync = 1'b0;
    vga.i_vga_hsync = 1'b0;
    vga.i_vga_de    = 1'b0;
    vga.i_raw_data  = '0;

    // Reset state
    repeat (3) tick();
    check("rst_de",  32'(vga.o_vga_de), 32'd0);
    check("rst_vs",  32'(vga.o_vga_vsync), 32'd0);
    check("rst_rgb", 32'({vga.o_vga_r, vga.o_vga_g, vga.o_vga_b}), 32'd0);
    check("rst_ovf", 32'(o_line_ovf), 32'd0);
    s_rst_n = 1'b1;
    repeat (2) tick();

    // Latency: one DE/hsync cycle emerges exactly two cycles later, once
    vga.i_vga_de    = 1'b1;
    vga.i_vga_hsync = 1'b1;
    vga.i_raw_data  = 8'd77;
    tick();
    vga.i_vga_de    = 1'b0;
    vga.i_vga_hsync = 1'b0;
    vga.i_raw_data  = '0;
    check("lat_de_c1", 32'(vga.o_vga_de), 32'd0);
    tick();
    check("lat_de_c2", 32'(vga.o_vga_de), 32'd1);
    check("lat_hs_c2", 32'(vga.o_vga_hsync), 32'd1);
    check("lat_rgb_border", 32'({vga.o_vga_r, vga.o_vga_g, vga.o_vga_b}), 32'd0);
    tick();
    check("lat_de_c3", 32'(vga.o_vga_de), 32'd0);
    repeat (3) tick();

    // Flat RGGB frame, then the same data read as BGGR
    fill_flat();
    drive_frame(2'd0, 2'd0, 4, 4);
    check_frame("rggb", 4, 4, RGGB_RGB);
    drive_frame(2'd3, 2'd3, 4, 4);
    check_frame("bggr", 4, 4, SWAP_RGB);

    // Pattern changed right after vsync is ignored until the next vsync
    drive_frame(2'd3, 2'd0, 4, 4);
    check_frame("midchg", 4, 4, SWAP_RGB);
    drive_frame(2'd0, 2'd0, 4, 4);
    check_frame("newvs", 4, 4, RGGB_RGB);

    // Rounding of the green average at both interpolation sites
    for (int r = 0; r < MAX_R; r++)
      for (int c = 0; c < MAX_C; c++)
        pix[r][c] = '0;
    pix[0][1] = 8'd255;
    pix[1][0] = 8'd254;
    pix[1][1] = 8'd9;
    pix[1][2] = 8'd254;
    drive_frame(2'd0, 2'd0, 2, 3);
    check("rnd_hi_b_site", 32'(cap[1][1]), 32'({8'd0, 8'd255, 8'd9}));
    check("rnd_hi_g_site", 32'(cap[1][2]), 32'({8'd0, 8'd255, 8'd9}));
    pix[0][1] = 8'd1;
    pix[1][0] = 8'd0;
    pix[1][2] = 8'd0;
    drive_frame(2'd0, 2'd0, 2, 3);
    check("rnd_lo_b_site", 32'(cap[1][1]), 32'({8'd0, 8'd1, 8'd9}));
    check("rnd_lo_g_site", 32'(cap[1][2]), 32'({8'd0, 8'd1, 8'd9}));

    // Overlong lines: columns past LINE_MAX are black and the flag sticks
    fill_flat();
    check("ovf_before", 32'(o_line_ovf), 32'd0);
    drive_frame(2'd0, 2'd0, 3, 10);
    check_frame("ovf", 3, 10, RGGB_RGB);
    check("ovf_sticky", 32'(o_line_ovf), 32'd1);
    drive_frame(2'd0, 2'd0, 4, 4);
    check("ovf_vs_clear", 32'(o_line_ovf), 32'd0);
    check_frame("after_ovf", 4, 4, RGGB_RGB);

    // Asynchronous reset in the middle of an overlong line
    vga.i_vga_hsync = 1'b1;
    tick();
    vga.i_vga_hsync = 1'b0;
    for (int c = 0; c < 9; c++) begin
      vga.i_vga_de   = 1'b1;
      vga.i_raw_data = pix[0][c];
      tick();
    end
    check("pre_rst_de", 32'(vga.o_vga_de), 32'd1);
    check("pre_rst_ovf", 32'(o_line_ovf), 32'd1);
    #3;
    s_rst_n        = 1'b0;
    vga.i_vga_de   = 1'b0;
    vga.i_raw_data = '0;
    #1;
    check("arst_de",  32'(vga.o_vga_de), 32'd0);
    check("arst_ovf", 32'(o_line_ovf), 32'd0);
    check("arst_rgb", 32'({vga.o_vga_r, vga.o_vga_g, vga.o_vga_b}), 32'd0);
    repeat (2) tick();
    s_rst_n = 1'b1;
    repeat (2) tick();

    drive_frame(2'd0, 2'd0, 4, 4);
    check_frame("recover", 4, 4, RGGB_RGB);
    check("recover_ovf", 32'(o_line_ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
